// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : disp_pkg
//  Purpose : Shared definitions for the display scan path: BCD digit width,
//            segment-off pattern, all-anodes-off helper and scan FSM states.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package disp_pkg;

  localparam int BCD_W      = 4;
  localparam int MAX_DIGITS = 32;

  // Segment pattern that leaves every (active-low) segment dark.
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Active-low anode word with every anode disabled; callers keep the low
  // NUM_DIGITS bits.
  function automatic logic [MAX_DIGITS-1:0] an_off();
    return {MAX_DIGITS{1'b1}};
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    ON    = 2'd2
  } scan_state_t;

endpackage : disp_pkg
`default_nettype wire

// File: rtl/display_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module  : display_scan_ctrl_if
//  Purpose : Bundles the digit data/control inputs and the display pin
//            outputs of the scan controller.
//  Signals : enable, digits_bcd[4*N], dp_mask[N], blank_mask[N], brightness[4]
//            (source -> controller); hex_digit[4], dp_n, an_n[N], frame_start
//            (controller -> board / decoder).
//  Modports: master = digit source side, slave = scan controller.
//  Rev     : 1.0  initial release
// ============================================================================
interface display_scan_ctrl_if #(
  parameter int NUM_DIGITS = 8
);
  logic                    enable;
  logic [4*NUM_DIGITS-1:0] digits_bcd;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [3:0]              brightness;
  logic [3:0]              hex_digit;
  logic                    dp_n;
  logic [NUM_DIGITS-1:0]   an_n;
  logic                    frame_start;

  modport master (
    output enable, digits_bcd, dp_mask, blank_mask, brightness,
    input  hex_digit, dp_n, an_n, frame_start
  );

  modport slave (
    input  enable, digits_bcd, dp_mask, blank_mask, brightness,
    output hex_digit, dp_n, an_n, frame_start
  );

endinterface : display_scan_ctrl_if
`default_nettype wire

// File: rtl/scan_timer.sv
`default_nettype none
// ============================================================================
//  Module  : scan_timer
//  Purpose : Slot cycle counter and digit index counter for the display scan,
//            plus frame_start generation. Next-state values are exported so the
//            parent can register its outputs aligned with the counters.
//  Ports   : clk, rst_n         clock, async active-low reset
//            run                 1 = scanning, 0 = counters forced to 0
//            restart             1 = first active cycle after idle
//            slot_cnt            current cycle k within the slot
//            cnt_nxt, idx_nxt    counter values for the next cycle
//            slot_load           next cycle is cycle 0 of a slot
//            frame_load          next cycle is cycle 0 of slot 0
//            frame_start         registered 1-cycle pulse in cycle 0 of slot 0
//  Rev     : 1.0  initial release
// ============================================================================
module scan_timer #(
  parameter int SCAN_DIV   = 50000,
  parameter int NUM_DIGITS = 8,
  localparam int CNT_W     = $clog2(SCAN_DIV),
  localparam int IDX_W     = $clog2(NUM_DIGITS)
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             run,
  input  wire logic             restart,
  output logic [CNT_W-1:0]      slot_cnt,
  output logic [CNT_W-1:0]      cnt_nxt,
  output logic [IDX_W-1:0]      idx_nxt,
  output logic                  slot_load,
  output logic                  frame_load,
  output logic                  frame_start
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [IDX_W-1:0] dig_idx;

  always_comb begin
    cnt_nxt    = slot_cnt + CNT_W'(1);
    idx_nxt    = dig_idx;
    slot_load  = 1'b0;
    frame_load = 1'b0;
    if (!run) begin
      cnt_nxt = '0;
      idx_nxt = '0;
    end else if (restart) begin
      // Leaving idle: counters already sit at 0, so the next cycle is
      // cycle 0 of slot 0 of a fresh frame.
      cnt_nxt    = '0;
      idx_nxt    = '0;
      slot_load  = 1'b1;
      frame_load = 1'b1;
    end else if (slot_cnt == CNT_LAST) begin
      cnt_nxt    = '0;
      idx_nxt    = (dig_idx == IDX_LAST) ? '0 : dig_idx + IDX_W'(1);
      slot_load  = 1'b1;
      frame_load = (dig_idx == IDX_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt    <= '0;
      dig_idx     <= '0;
      frame_start <= 1'b0;
    end else begin
      slot_cnt    <= cnt_nxt;
      dig_idx     <= idx_nxt;
      frame_start <= frame_load;
    end
  end

endmodule : scan_timer
`default_nettype wire

// File: rtl/display_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : display_scan_ctrl
//  Purpose : Time-multiplexed scan controller for a multi-digit 7-segment
//            display. Selects one BCD digit per slot for the shared decoder,
//            drives that digit's active-low anode, and adds dead time,
//            16-level brightness PWM, per-digit blanking and decimal points.
//  Ports   : clk        system clock
//            rst_n      asynchronous active-low reset
//            bus        display_scan_ctrl_if.slave:
//                         in  enable, digits_bcd, dp_mask, blank_mask,
//                             brightness
//                         out hex_digit, dp_n, an_n, frame_start
//  Rev     : 1.0  initial release
// ============================================================================
module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 500
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  display_scan_ctrl_if.slave bus
);

  localparam int ON_STEP = (SCAN_DIV - BLANK_CYC) / 16;
  localparam int CNT_W   = $clog2(SCAN_DIV);
  localparam int IDX_W   = $clog2(NUM_DIGITS);
  // One extra bit lets the lit-cycle offset and the lit length (up to
  // 16*ON_STEP < SCAN_DIV) share a width without overflow.
  localparam int LIT_W   = CNT_W + 1;

  localparam logic [MAX_DIGITS-1:0] AN_OFF_WIDE = an_off();
  localparam logic [NUM_DIGITS-1:0] AN_OFF      = AN_OFF_WIDE[NUM_DIGITS-1:0];

  // --------------------------------------------------------------------------
  // Timer
  // --------------------------------------------------------------------------
  scan_state_t         state;
  scan_state_t         state_nxt;
  logic [CNT_W-1:0]    slot_cnt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic [IDX_W-1:0]    idx_nxt;
  logic                slot_load;
  logic                frame_load;
  logic                frame_start;

  scan_timer #(
    .SCAN_DIV   (SCAN_DIV),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_scan_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (bus.enable),
    .restart     (state == IDLE),
    .slot_cnt    (slot_cnt),
    .cnt_nxt     (cnt_nxt),
    .idx_nxt     (idx_nxt),
    .slot_load   (slot_load),
    .frame_load  (frame_load),
    .frame_start (frame_start)
  );

  // --------------------------------------------------------------------------
  // FSM: state tracks the phase of the slot cycle held in slot_cnt
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.enable) state_nxt = BLANK;
      BLANK:   if (slot_cnt == CNT_W'(BLANK_CYC - 1)) state_nxt = ON;
      ON:      if (slot_cnt == CNT_W'(SCAN_DIV - 1)) state_nxt = BLANK;
      default: state_nxt = IDLE;
    endcase
    if (!bus.enable) begin
      state_nxt = IDLE;
    end
  end

  // --------------------------------------------------------------------------
  // Per-frame snapshot, taken on the edge that starts slot 0
  // --------------------------------------------------------------------------
  logic [BCD_W*NUM_DIGITS-1:0] digits_snap;
  logic [NUM_DIGITS-1:0]       dp_snap;
  logic [NUM_DIGITS-1:0]       blank_snap;
  logic [3:0]                  bright_snap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_snap <= '0;
      dp_snap     <= '0;
      blank_snap  <= '0;
      bright_snap <= '0;
    end else if (frame_load) begin
      digits_snap <= bus.digits_bcd;
      dp_snap     <= bus.dp_mask;
      blank_snap  <= bus.blank_mask;
      bright_snap <= bus.brightness;
    end
  end

  // --------------------------------------------------------------------------
  // Output next-values, computed against the next counter values so the
  // registered outputs line up with slot cycle k.
  // --------------------------------------------------------------------------
  logic [LIT_W-1:0]            lit_len;
  logic [LIT_W-1:0]            lit_ofs;
  logic                        lit_window;
  logic [BCD_W*NUM_DIGITS-1:0] digit_src;
  logic [NUM_DIGITS-1:0]       an_nxt;
  logic                        dp_nxt;
  logic [3:0]                  hex_nxt;
  logic [3:0]                  hex_digit_q;
  logic [NUM_DIGITS-1:0]       an_n_q;
  logic                        dp_n_q;

  always_comb begin
    lit_len    = LIT_W'(ON_STEP) * (LIT_W'(bright_snap) + LIT_W'(1));
    // Only meaningful in ON, where cnt_nxt >= BLANK_CYC.
    lit_ofs    = {1'b0, cnt_nxt} - LIT_W'(BLANK_CYC);
    lit_window = (state_nxt == ON) && (lit_ofs < lit_len);
    // On the frame edge the snapshot is being loaded this same cycle, so the
    // first digit comes straight from the live inputs.
    digit_src  = frame_load ? bus.digits_bcd : digits_snap;
    an_nxt     = AN_OFF;
    dp_nxt     = 1'b1;
    hex_nxt    = hex_digit_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_nxt == IDX_W'(i)) begin
        hex_nxt = digit_src[i*BCD_W +: BCD_W];
        if (lit_window && !blank_snap[i]) begin
          an_nxt[i] = 1'b0;
          dp_nxt    = ~dp_snap[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex_digit_q <= 4'hF;
      an_n_q      <= AN_OFF;
      dp_n_q      <= 1'b1;
    end else begin
      an_n_q <= an_nxt;
      dp_n_q <= dp_nxt;
      // Digit changes only on slot cycle 0, inside the dead time.
      if (slot_load) begin
        hex_digit_q <= hex_nxt;
      end
    end
  end

  assign bus.hex_digit   = hex_digit_q;
  assign bus.an_n        = an_n_q;
  assign bus.dp_n        = dp_n_q;
  assign bus.frame_start = frame_start;

endmodule : display_scan_ctrl
`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : tb_display_scan_ctrl
//  Purpose : Directed self-checking bench for display_scan_ctrl with
//            NUM_DIGITS=4, SCAN_DIV=20, BLANK_CYC=4 (ON_STEP=1, frame=80).
//  Rev     : 1.0  initial release
// ============================================================================
module tb_display_scan_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   errors = 0;
  int   checks = 0;
  bit   mon_on = 1'b0;
  logic [3:0] prev_hex = 4'hF;

  display_scan_ctrl_if #(.NUM_DIGITS(4)) bus ();

  display_scan_ctrl #(
    .NUM_DIGITS (4),
    .SCAN_DIV   (20),
    .BLANK_CYC  (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // At most one anode low; no anode low while the digit changes.
  always @(negedge clk) begin
    if (mon_on) begin
      checks++;
      if ($countones(~bus.an_n) > 1 || (bus.hex_digit !== prev_hex && bus.an_n !== 4'hF)) begin
        errors++;
        $display("FAIL invariant: an_n=%b hex_digit=%h prev_hex=%h", bus.an_n, bus.hex_digit, prev_hex);
      end
      prev_hex = bus.hex_digit;
    end
  end

  task automatic wait_frame(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.frame_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.enable = 1'b0; bus.digits_bcd = 16'h0; bus.dp_mask = 4'h0;
    bus.blank_mask = 4'h0; bus.brightness = 4'hF;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.an_n !== 4'b1111 || bus.dp_n !== 1'b1 || bus.hex_digit !== 4'hF || bus.frame_start !== 1'b0) begin
      errors++;
      $display("FAIL reset: an_n=%b dp_n=%b hex=%h fs=%b, want 1111 1 f 0", bus.an_n, bus.dp_n, bus.hex_digit, bus.frame_start);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      checks++;
      if (bus.an_n !== 4'b1111 || bus.dp_n !== 1'b1 || bus.hex_digit !== 4'hF || bus.frame_start !== 1'b0) begin
        errors++;
        $display("FAIL idle c=%0d: an_n=%b dp_n=%b hex=%h fs=%b, want 1111 1 f 0", c, bus.an_n, bus.dp_n, bus.hex_digit, bus.frame_start);
      end
    end
    prev_hex = bus.hex_digit;
    mon_on = 1'b1;
  endtask

  task automatic test_full_scan();
    bit ok;
    logic [3:0] exp_an, exp_hex;
    bus.digits_bcd = 16'h4321; bus.brightness = 4'd15; bus.enable = 1'b1;
    wait_frame(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL full_scan_sync: frame_start=0 after 200 cycles, want 1");
      return;
    end
    for (int c = 0; c < 81; c++) begin
      int slot, k;
      slot = (c % 80) / 20; k = c % 20;
      if (c > 0) @(negedge clk);
      exp_an  = (k >= 4) ? ~(4'b0001 << slot) : 4'b1111;
      exp_hex = 4'(slot + 1);
      checks++;
      if (bus.an_n !== exp_an || bus.hex_digit !== exp_hex || bus.dp_n !== 1'b1 || bus.frame_start !== ((c % 80) == 0)) begin
        errors++;
        $display("FAIL full_scan c=%0d: an_n=%b hex=%h dp_n=%b fs=%b, want %b %h 1 %b", c, bus.an_n, bus.hex_digit, bus.dp_n, bus.frame_start, exp_an, exp_hex, (c % 80) == 0);
      end
    end
  endtask

  task automatic test_brightness();
    bit ok;
    int br_seq[3] = '{15, 0, 7};
    logic [3:0] exp_an;
    wait_frame(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL brightness_sync: frame_start=0 after 200 cycles, want 1");
      return;
    end
    for (int c = 0; c < 240; c++) begin
      int f, slot, k;
      f = c / 80; slot = (c % 80) / 20; k = c % 20;
      if (c > 0) @(negedge clk);
      exp_an = (k >= 4 && (k - 4) < br_seq[f] + 1) ? ~(4'b0001 << slot) : 4'b1111;
      checks++;
      if (bus.an_n !== exp_an || bus.frame_start !== ((c % 80) == 0)) begin
        errors++;
        $display("FAIL brightness c=%0d br=%0d: an_n=%b fs=%b, want %b %b", c, br_seq[f], bus.an_n, bus.frame_start, exp_an, (c % 80) == 0);
      end
      // Mid-frame change: must only show up in the next frame.
      if ((c % 80) == 0 && f < 2) bus.brightness = 4'(br_seq[f + 1]);
    end
  endtask

  task automatic test_masks();
    bit ok, lit;
    logic [3:0] exp_an;
    logic exp_dp;
    bus.brightness = 4'd15; bus.blank_mask = 4'b0100; bus.dp_mask = 4'b0010;
    wait_frame(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL masks_sync: frame_start=0 after 200 cycles, want 1");
      return;
    end
    for (int c = 0; c < 80; c++) begin
      int slot, k;
      slot = c / 20; k = c % 20;
      if (c > 0) @(negedge clk);
      lit    = (k >= 4) && (slot != 2);
      exp_an = lit ? ~(4'b0001 << slot) : 4'b1111;
      exp_dp = !(lit && slot == 1);
      checks++;
      if (bus.an_n !== exp_an || bus.dp_n !== exp_dp) begin
        errors++;
        $display("FAIL masks c=%0d: an_n=%b dp_n=%b, want %b %b", c, bus.an_n, bus.dp_n, exp_an, exp_dp);
      end
    end
    bus.blank_mask = 4'h0; bus.dp_mask = 4'h0;
  endtask

  task automatic test_snapshot();
    bit ok;
    logic [3:0] exp_an, exp_hex;
    bus.digits_bcd = 16'h4321;
    wait_frame(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL snapshot_sync: frame_start=0 after 200 cycles, want 1");
      return;
    end
    for (int c = 0; c < 160; c++) begin
      int slot, k;
      slot = (c % 80) / 20; k = c % 20;
      if (c > 0) @(negedge clk);
      exp_hex = (c < 80) ? 4'(slot + 1) : 4'h9;
      exp_an  = (k >= 4) ? ~(4'b0001 << slot) : 4'b1111;
      checks++;
      if (bus.hex_digit !== exp_hex || bus.an_n !== exp_an) begin
        errors++;
        $display("FAIL snapshot c=%0d: hex=%h an_n=%b, want %h %b", c, bus.hex_digit, bus.an_n, exp_hex, exp_an);
      end
      if (c == 25) bus.digits_bcd = 16'h9999;
    end
  endtask

  task automatic test_disturbance();
    bit ok;
    bus.digits_bcd = 16'h4321;
    wait_frame(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL disturb_sync: frame_start=0 after 200 cycles, want 1");
      return;
    end
    repeat (50) @(negedge clk);
    checks++;
    if (bus.an_n !== 4'b1011 || bus.hex_digit !== 4'h3) begin
      errors++; $display("FAIL disturb_pre: an_n=%b hex=%h, want 1011 3", bus.an_n, bus.hex_digit);
    end
    bus.enable = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.an_n !== 4'b1111 || bus.dp_n !== 1'b1) begin
      errors++; $display("FAIL disable_dark: an_n=%b dp_n=%b, want 1111 1", bus.an_n, bus.dp_n);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (bus.an_n !== 4'b1111 || bus.frame_start !== 1'b0) begin
      errors++; $display("FAIL disable_hold: an_n=%b fs=%b, want 1111 0", bus.an_n, bus.frame_start);
    end
    bus.enable = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.frame_start !== 1'b1 || bus.an_n !== 4'b1111 || bus.hex_digit !== 4'h1) begin
      errors++; $display("FAIL reenable: fs=%b an_n=%b hex=%h, want 1 1111 1", bus.frame_start, bus.an_n, bus.hex_digit);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (bus.an_n !== 4'b1110) begin
      errors++; $display("FAIL reenable_lit: an_n=%b, want 1110", bus.an_n);
    end
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.an_n !== 4'b1111 || bus.dp_n !== 1'b1 || bus.hex_digit !== 4'hF || bus.frame_start !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: an_n=%b dp_n=%b hex=%h fs=%b, want 1111 1 f 0", bus.an_n, bus.dp_n, bus.hex_digit, bus.frame_start);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.frame_start !== 1'b1 || bus.an_n !== 4'b1111 || bus.hex_digit !== 4'h1) begin
      errors++; $display("FAIL post_reset: fs=%b an_n=%b hex=%h, want 1 1111 1", bus.frame_start, bus.an_n, bus.hex_digit);
    end
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_brightness();
    test_masks();
    test_snapshot();
    test_disturbance();
    repeat (3) @(negedge clk);
    mon_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_display_scan_ctrl
`default_nettype wire
